// File: rtl/rv_regfile.sv
// ---------------------------------------------------------------------------
// rv_regfile -- RV32I integer register file
//
// Purpose:
//   Feeds the rs1/rs2 operands to the ALU. It has two combinational read
//   ports and one synchronous write port, and x0 always reads as zero.
//   After every reset, a small sequencer writes zero into x1..x(NREGS-1),
//   one register per cycle. While that runs, busy is high, so the core can
//   stall fetch until the file holds valid data.
//
// Parameters:
//   XLEN   data width in bits
//   NREGS  number of architectural registers, including x0
//   AW     address width; must equal clog2(NREGS)
//
// Ports:
//   clk       in   1     clock; every state change happens on the rising edge
//   rst_n     in   1     synchronous, active-low reset
//   rs1_addr  in   AW    read port 1 address
//   rs2_addr  in   AW    read port 2 address
//   rs1_data  out  XLEN  read port 1 data (combinational)
//   rs2_data  out  XLEN  read port 2 data (combinational)
//   we        in   1     write enable
//   rd_addr   in   AW    write address
//   rd_data   in   XLEN  write data
//   busy      out  1     high while reset is held or the clear sequence runs
//   wr_drop   out  1     one-cycle pulse: a write arrived while busy and was
//                        dropped
//
// Build option:
//   RV_REGFILE_BYPASS_EN
//     When defined, a write in RUN is forwarded to any read port that
//     addresses the same register in the same cycle.
//     When undefined, a read returns the old value in the write cycle and
//     the new value from the next cycle.
// ---------------------------------------------------------------------------
module rv_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd_data,
   output logic            busy,
   output logic            wr_drop
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
   logic            wr_drop_reg, wr_drop_next;

   // Storage has no reset of its own. The clear sequence initialises it.
   logic [XLEN-1:0] regs [NREGS];

   // The clear sequencer and the user write share the single write port.
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [XLEN-1:0] mem_wdata;

   // busy includes rst_n directly. Reads are therefore masked in the same
   // cycle that reset is asserted, not one edge later.
   assign busy    = !rst_n || (state_reg == ST_CLEAR);
   assign wr_drop = wr_drop_reg;

   // ------------------------------------------------------------------
   // Sequencer: next state and write-port steering
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      wr_drop_next = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = rd_addr;
      mem_wdata    = rd_data;
      case (state_reg)
         ST_CLEAR: begin
            mem_we       = 1'b1;
            mem_waddr    = clr_cnt_reg;
            mem_wdata    = '0;
            clr_cnt_next = clr_cnt_reg + AW'(1);
            // A user write that arrives during the clear is lost.
            // It is flagged on the next cycle.
            wr_drop_next = we;
            if (clr_cnt_reg == AW'(NREGS - 1))
               state_next = ST_RUN;
         end
         ST_RUN: begin
            // Writes to x0 are discarded silently.
            mem_we = we && (rd_addr != '0);
         end
         default: begin
            state_next   = ST_CLEAR;
            clr_cnt_next = AW'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_CLEAR;
         clr_cnt_reg <= AW'(1);
         wr_drop_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
         wr_drop_reg <= wr_drop_next;
      end
   end

   // Reset has priority. No write of any kind lands on a reset edge.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we)
         regs[mem_waddr] <= mem_wdata;
   end

   // ------------------------------------------------------------------
   // Read ports: one identical instance per port
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = (gi == 0) ? rs1_addr : rs2_addr;

      always_comb begin
         data = '0;
         if (!busy && (addr != '0)) begin
            data = regs[addr];
`ifdef RV_REGFILE_BYPASS_EN
            // Forward the write that is about to commit this cycle.
            if (we && (rd_addr != '0) && (rd_addr == addr))
               data = rd_data;
`endif
         end
      end
   end

   assign rs1_data = g_rd[0].data;
   assign rs2_data = g_rd[1].data;

endmodule

// File: tb/tb_rv_regfile.sv
// ---------------------------------------------------------------------------
// tb_rv_regfile -- self-checking bench for rv_regfile
//
// The reference model tracks only three things:
//   - how many clear cycles remain,
//   - the architectural register contents,
//   - the expected wr_drop value.
// The bench compares every DUT output against this model on each cycle.
// It runs directed scenarios and randomised traffic.
// ---------------------------------------------------------------------------
module tb_rv_regfile;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic        we;
   logic        busy, wr_drop;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   int          m_clear_left;
   logic        m_wr_drop;

   rv_regfile #(.XLEN(32), .NREGS(32), .AW(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .we       (we),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .wr_drop  (wr_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic exp_busy();
      return !rst_n || (m_clear_left > 0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (exp_busy() || a == 5'd0) return 32'h0;
`ifdef RV_REGFILE_BYPASS_EN
      if (we && rd_addr != 5'd0 && rd_addr == a) return rd_data;
`endif
      return m_regs[a];
   endfunction

   // Generic comparison helper; every call counts as one check.
   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Compare all outputs with the model for the current cycle.
   task automatic check(input string tag);
      #1;
      $display("[%0t] %s rst_n=%b we=%b rd=%0d wd=%h rs1=%0d:%h rs2=%0d:%h busy=%b wr_drop=%b",
               $time, tag, rst_n, we, rd_addr, rd_data, rs1_addr, rs1_data,
               rs2_addr, rs2_data, busy, wr_drop);
      cmp({tag, ".busy"},    {31'b0, busy},    {31'b0, exp_busy()});
      cmp({tag, ".wr_drop"}, {31'b0, wr_drop}, {31'b0, m_wr_drop});
      cmp({tag, ".rs1"},     rs1_data,         exp_read(rs1_addr));
      cmp({tag, ".rs2"},     rs2_data,         exp_read(rs2_addr));
   endtask

   // Advance one clock edge and apply the spec's rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_clear_left = 31;
         m_wr_drop    = 1'b0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else if (m_clear_left > 0) begin
         m_wr_drop = we;
         m_clear_left--;
      end else begin
         m_wr_drop = 1'b0;
         if (we && rd_addr != 5'd0) m_regs[rd_addr] = rd_data;
      end
      #1;
   endtask

   task automatic idle_inputs();
      we       = 1'b0;
      rd_addr  = 5'd0;
      rd_data  = 32'h0;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
   endtask

   int n_busy;

   initial begin
      m_clear_left = 31;
      m_wr_drop    = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      rst_n = 1'b0;
      idle_inputs();
      rs1_addr = 5'd9;
      rs2_addr = 5'd17;

      // ---- Test 1: reset for 2 cycles, then 31 busy cycles ----
      for (int i = 0; i < 2; i++) begin
         check("rst");
         tick();
      end
      rst_n  = 1'b1;
      n_busy = 0;
      while (busy && n_busy < 100) begin
         rs1_addr = 5'($urandom);
         rs2_addr = 5'($urandom);
         check("clr");
         tick();
         n_busy++;
      end
      cmp("t1.busy_cycles", 32'(n_busy), 32'd31);
      cmp("t1.busy_after", {31'b0, busy}, 32'h0);

      // ---- Test 2: write then read the same register on both ports ----
      we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
      check("t2.wr");
      tick();
      idle_inputs();
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      check("t2.rd");
      cmp("t2.rs1", rs1_data, 32'hDEADBEEF);
      cmp("t2.rs2", rs2_data, 32'hDEADBEEF);

      // ---- Test 3: a write to x0 is discarded without a wr_drop pulse ----
      we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
      check("t3.wr");
      tick();
      idle_inputs();
      check("t3.rd");
      cmp("t3.rs1", rs1_data, 32'h0);
      cmp("t3.wr_drop", {31'b0, wr_drop}, 32'h0);

      // ---- Test 4: read and write the same register in one cycle ----
      we = 1'b1; rd_addr = 5'd7; rd_data = 32'h1;
      check("t4.init");
      tick();
      we = 1'b1; rd_addr = 5'd7; rd_data = 32'h2; rs1_addr = 5'd7;
      check("t4.same");
`ifdef RV_REGFILE_BYPASS_EN
      cmp("t4.same_rs1", rs1_data, 32'h2);
`else
      cmp("t4.same_rs1", rs1_data, 32'h1);
`endif
      tick();
      idle_inputs();
      rs1_addr = 5'd7;
      check("t4.next");
      cmp("t4.next_rs1", rs1_data, 32'h2);

      // ---- Test 5: a write during the clear is dropped and flagged ----
      we = 1'b1; rd_addr = 5'd3; rd_data = 32'h77;
      check("t5.pre");
      tick();
      idle_inputs();
      rst_n = 1'b0;
      check("t5.rst");
      tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         idle_inputs();
         if (c == 10) begin
            we = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5;
         end
         check("t5.clr");
         tick();
         if (c == 10) cmp("t5.drop_pulse", {31'b0, wr_drop}, 32'h1);
         if (c == 11) cmp("t5.drop_end", {31'b0, wr_drop}, 32'h0);
      end
      idle_inputs();
      rs1_addr = 5'd3;
      check("t5.rd");
      cmp("t5.x3", rs1_data, 32'h0);

      // ---- Random traffic with occasional reset ----
      for (int i = 0; i < 500; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         we       = 1'($urandom_range(0, 1));
         rd_addr  = 5'($urandom);
         rd_data  = $urandom;
         rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
         rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
         check("rnd");
         tick();
      end

      // Make sure several registers hold non-zero values before the next test.
      rst_n = 1'b1;
      idle_inputs();
      n_busy = 0;
      while (busy && n_busy < 100) begin
         check("drain");
         tick();
         n_busy++;
      end
      cmp("drain.idle", {31'b0, busy}, 32'h0);
      for (int a = 1; a < 32; a++) begin
         we = 1'b1; rd_addr = 5'(a); rd_data = $urandom | 32'h1;
         check("fill");
         tick();
      end

      // ---- Test 6: reset in the middle of the clear ----
      idle_inputs();
      rst_n = 1'b0;
      check("t6.rst");
      tick();
      rst_n = 1'b1;
      for (int c = 1; c < 20; c++) begin
         check("t6.clr");
         tick();
      end
      // Write with we=1 on the reset edge: reset wins, so wr_drop must stay 0.
      rst_n = 1'b0; we = 1'b1; rd_addr = 5'd4; rd_data = 32'h55;
      check("t6.midrst");
      tick();
      cmp("t6.no_drop", {31'b0, wr_drop}, 32'h0);
      rst_n = 1'b1;
      idle_inputs();
      n_busy = 0;
      while (busy && n_busy < 100) begin
         check("t6.reclr");
         tick();
         n_busy++;
      end
      cmp("t6.busy_cycles", 32'(n_busy), 32'd31);
      for (int a = 1; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(32 - a);
         check("t6.rd");
         cmp("t6.zero", rs1_data, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
